dds_multich_dac: RTL and testbench
==================================

# dds_multich_dac

Parametrised multi-channel DDS waveform generator driving AD9767-style dual/multi DACs. It is the next-generation replacement for the fixed two-channel key-driven DDS: the channel count and the phase, data and LUT widths are generic. Each channel has its own waveform select, frequency step and phase step, plus an optional linear frequency sweep. It sits between the key debounce front end (one-cycle pulses in) and the DAC pins (data, clock and write strobes out).

## Interface
- NUM_CH, 2, number of independent channels
- PHASE_W, 32, phase accumulator width; must be ≥ DATA_W+1 and ≥ LUT_ADDR_W
- DATA_W, 14, DAC sample width, straight (offset) binary
- LUT_ADDR_W, 10, sine ROM address width (full-cycle table)
- SAMPLE_DIV, 4, Clk cycles per output sample; even, ≥ 4
- FREQ_LEVELS, 8, number of frequency steps; index wraps after FREQ_LEVELS-1
- FTW_BASE, 343597, tuning word for index 0 (≈1 kHz at 50 MHz Clk, SAMPLE_DIV 4)
- SWEEP_INC, 1000, FTW increment per sample in sweep mode
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Freq_Step  in  NUM_CH  one-cycle pulse per channel: advance frequency index
- Phase_Step  in  NUM_CH  one-cycle pulse per channel: add 45° phase offset
- Mode_Sel  in  2*NUM_CH  per channel: 0 sine, 1 square, 2 triangle, 3 sawtooth
- Sweep_En  in  NUM_CH  per channel sweep enable (see Configuration)
- Data  out  NUM_CH*DATA_W  channel k occupies [k*DATA_W +: DATA_W]
- Dac_Clk  out  NUM_CH  DAC clock per channel
- Dac_Wrt  out  NUM_CH  DAC write strobe per channel (identical to Dac_Clk)

## Operation
- Shared sample counter cnt runs 0..SAMPLE_DIV-1 and wraps. A sample strobe occurs at cnt==0.
- Per channel, at the strobe: acc <= acc + FTW (mod 2^PHASE_W). FTW = (FTW_BASE << idx) truncated to PHASE_W bits.
- Freq_Step: idx <= idx+1; at FREQ_LEVELS-1 it wraps to 0. Takes effect at the next strobe.
- Phase_Step: off <= off + 2^(PHASE_W-3), wraps naturally mod 2^PHASE_W.
- Pulses are accepted on any cycle. Pulses on several channels in the same cycle are all applied. A Freq_Step and a Phase_Step on the same channel in the same cycle are both applied.
- Output phase is p = acc + off.
- Sine: ROM[p[PHASE_W-1 -: LUT_ADDR_W]]. ROM[0] = 2^(DATA_W-1), i.e. midscale.
- Square: all-ones if p MSB is 0, otherwise 0.
- Sawtooth: p[PHASE_W-1 -: DATA_W].
- Triangle: t = p[PHASE_W-2 -: DATA_W]; output t if MSB is 0, otherwise ~t.
- Mode_Sel is sampled at the strobe only.
- Reset values: cnt = SAMPLE_DIV/2; acc, off, idx and Data are 0; Dac_Clk and Dac_Wrt are 0; sweep registers hold FTW_BASE.
- Reset asserted mid-sample returns every register to its reset value immediately. No partial sample is written.

## Timing
- Pipeline: acc updates on the edge into cnt==1, ROM/waveform register on the edge into cnt==2, Data updates on the edge into cnt==3. Latency is 3 Clk from the strobe.
- Dac_Clk and Dac_Wrt are registered and high exactly while cnt ∈ [0, SAMPLE_DIV/2-1].
- The rising edge therefore follows a Data change by ≥1 Clk, and Data is stable from the rising edge until ≥1 Clk after the falling edge.
- After Reset deasserts, the first Dac_Wrt rising edge falls SAMPLE_DIV/2 Clk later. The first valid sample appears at Data 3 Clk after the first strobe.
- A step pulse arriving in the strobe cycle itself is applied at the following strobe.

## Configuration
- DDS_SWEEP_EN defined: each channel has a sweep register sw.
  - While Sweep_En[k] is high, sw is the effective FTW. At each strobe, sw <= sw + SWEEP_INC; if sw ≥ the selected FTW, sw <= FTW_BASE instead.
  - While Sweep_En[k] is low, sw is held at FTW_BASE.
- DDS_SWEEP_EN undefined: no sweep registers are built. The Sweep_En port exists but is ignored, and behaviour equals Sweep_En tied to 0.

## Structure
- Package dds_pkg holds:
  - the mode encoding constants (sine, square, triangle, saw);
  - the phase step constant 2^(PHASE_W-3) expressed as a shift amount of 3;
  - the default parameter values listed above.
- Sub-module dds_sine_rom is instantiated once per channel. It is a synchronous-read full-cycle sine table of 2^LUT_ADDR_W × DATA_W entries, offset binary, initialised from a generated table.

## Test plan
- Reset held 200 ns, then released → Data = 0 and Dac_Wrt = Dac_Clk = 0 during reset. First Dac_Wrt rise occurs 2 Clk after release; thereafter Dac_Wrt has period 4 Clk.
- FTW_BASE = 2^18, ch0 mode 3, idx 0 → Data[0] increments by exactly 1 per sample and wraps 16383 → 0.
- Same setup, 3 Freq_Step[0] pulses → increment of 8 per sample. 8 pulses total → back to increment 1. Ch1 is unaffected.
- Both channels in mode 3 at the same FTW, 2 Phase_Step[1] pulses → (Data1 − Data0) mod 16384 = 4096.
- Mode 1 → ch0 shows only 16383/0 with a 50 % duty cycle. Mode 0 after reset → first sample is 8192. Freq_Step on both channels in the same cycle → both idx advance. Reset mid-sample → all outputs return to reset values within 1 Clk.
- DDS_SWEEP_EN defined, Sweep_En[0] = 1, idx = 1 → ch0 FTW rises from FTW_BASE in steps of 1000 per sample and reloads to FTW_BASE at 2·FTW_BASE. Without the macro, the same stimulus gives a constant FTW.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the multi-channel DDS: waveform encodings, phase step
// shift and default generics.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SAW    = 2'd3
  } mode_e;

  // Phase step of 45 degrees is 2^(PHASE_W-3).
  localparam int unsigned PHASE_STEP_SHIFT = 3;

  localparam int unsigned DEF_NUM_CH      = 2;
  localparam int unsigned DEF_PHASE_W     = 32;
  localparam int unsigned DEF_DATA_W      = 14;
  localparam int unsigned DEF_LUT_ADDR_W  = 10;
  localparam int unsigned DEF_SAMPLE_DIV  = 4;
  localparam int unsigned DEF_FREQ_LEVELS = 8;
  localparam int unsigned DEF_FTW_BASE    = 343597;
  localparam int unsigned DEF_SWEEP_INC   = 1000;

endpackage

// File: rtl/dds_sine_rom.sv
// Synchronous-read full-cycle sine table, offset binary, entry 0 at midscale.
module dds_sine_rom #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] q
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int          MID    = 1 << (DATA_W - 1);
  localparam int          AMP    = MID - 1;
  localparam real         TWO_PI = 6.283185307179586;

  logic [DATA_W-1:0] lut [DEPTH];

  // Rounded sample of one full period; evaluated once at elaboration.
  function automatic logic [DATA_W-1:0] sine_entry(input int unsigned i);
    real ang;
    real s;
    int  v;
    ang = TWO_PI * real'(i) / real'(DEPTH);
    s   = real'(AMP) * $sin(ang);
    v   = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
    return DATA_W'(MID + v);
  endfunction

  for (genvar i = 0; i < DEPTH; i++) begin : g_lut
    assign lut[i] = sine_entry(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= lut[addr];
    end
  end

endmodule

// File: rtl/dds_multich_dac.sv
// Multi-channel DDS driving AD9767-style DACs: per-channel frequency index,
// 45-degree phase steps and four waveforms. Define DDS_SWEEP_EN for linear FTW sweep.
module dds_multich_dac
  import dds_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned PHASE_W     = DEF_PHASE_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned LUT_ADDR_W  = DEF_LUT_ADDR_W,
  parameter int unsigned SAMPLE_DIV  = DEF_SAMPLE_DIV,
  parameter int unsigned FREQ_LEVELS = DEF_FREQ_LEVELS,
  parameter int unsigned FTW_BASE    = DEF_FTW_BASE,
  parameter int unsigned SWEEP_INC   = DEF_SWEEP_INC
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_CH-1:0]        Freq_Step,
  input  logic [NUM_CH-1:0]        Phase_Step,
  input  logic [2*NUM_CH-1:0]      Mode_Sel,
  input  logic [NUM_CH-1:0]        Sweep_En,
  output logic [NUM_CH*DATA_W-1:0] Data,
  output logic [NUM_CH-1:0]        Dac_Clk,
  output logic [NUM_CH-1:0]        Dac_Wrt
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);
  localparam int unsigned IDX_W = (FREQ_LEVELS > 1) ? $clog2(FREQ_LEVELS) : 1;
  localparam int unsigned HALF  = SAMPLE_DIV / 2;

  localparam logic [PHASE_W-1:0] BASE_W   = PHASE_W'(FTW_BASE);
  localparam logic [PHASE_W-1:0] PH_STEP  = PHASE_W'(1) << (PHASE_W - PHASE_STEP_SHIFT);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(FREQ_LEVELS - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             dac_clk_q;
  logic             strobe;
  logic             rom_stage;
  logic             out_stage;

  assign cnt_nxt   = (cnt == CNT_W'(SAMPLE_DIV - 1)) ? '0 : cnt + CNT_W'(1);
  assign strobe    = (cnt == CNT_W'(0));
  assign rom_stage = (cnt == CNT_W'(1));
  assign out_stage = (cnt == CNT_W'(2));

  // Shared sample counter; DAC clock is high for the first half of each sample.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt       <= CNT_W'(HALF);
      dac_clk_q <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      dac_clk_q <= (cnt_nxt < CNT_W'(HALF));
    end
  end

  assign Dac_Clk = {NUM_CH{dac_clk_q}};
  assign Dac_Wrt = {NUM_CH{dac_clk_q}};

`ifndef DDS_SWEEP_EN
  logic sweep_unused;
  assign sweep_unused = ^Sweep_En;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [IDX_W-1:0]   idx;
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] off;
    logic [PHASE_W-1:0] ph;
    logic [PHASE_W-1:0] ftw_sel;
    logic [PHASE_W-1:0] ftw_eff;
    logic [DATA_W-1:0]  tri_c;
    logic [DATA_W-1:0]  wave_c;
    logic [DATA_W-1:0]  wave_q;
    logic [DATA_W-1:0]  rom_q;
    logic [DATA_W-1:0]  data_q;
    mode_e              mode_q;
    logic               ph_unused;

    assign ftw_sel   = BASE_W << idx;
    assign ph_unused = ^ph;

`ifdef DDS_SWEEP_EN
    logic [PHASE_W-1:0] sw;

    // Sweep register ramps from the base word and reloads once it reaches the selected FTW.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        sw <= BASE_W;
      end else if (!Sweep_En[k]) begin
        sw <= BASE_W;
      end else if (strobe) begin
        sw <= (sw >= ftw_sel) ? BASE_W : sw + PHASE_W'(SWEEP_INC);
      end
    end

    assign ftw_eff = Sweep_En[k] ? sw : ftw_sel;
`else
    assign ftw_eff = ftw_sel;
`endif

    always_comb begin
      tri_c  = ph[PHASE_W-2 -: DATA_W];
      wave_c = '0;
      case (mode_q)
        MODE_SQUARE: wave_c = ph[PHASE_W-1] ? '0 : '1;
        MODE_TRI:    wave_c = ph[PHASE_W-1] ? ~tri_c : tri_c;
        MODE_SAW:    wave_c = ph[PHASE_W-1 -: DATA_W];
        default:     wave_c = '0;
      endcase
    end

    // Steps land any cycle; the output phase is captured at the strobe so a
    // step arriving in the strobe cycle only shows at the next sample.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        idx    <= '0;
        off    <= '0;
        acc    <= '0;
        ph     <= '0;
        mode_q <= MODE_SINE;
        wave_q <= '0;
        data_q <= '0;
      end else begin
        if (Freq_Step[k]) begin
          idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
        if (Phase_Step[k]) begin
          off <= off + PH_STEP;
        end
        if (strobe) begin
          acc    <= acc + ftw_eff;
          ph     <= acc + ftw_eff + off;
          mode_q <= mode_e'(Mode_Sel[2*k +: 2]);
        end
        if (rom_stage) begin
          wave_q <= wave_c;
        end
        if (out_stage) begin
          data_q <= (mode_q == MODE_SINE) ? rom_q : wave_q;
        end
      end
    end

    dds_sine_rom #(
      .ADDR_W (LUT_ADDR_W),
      .DATA_W (DATA_W)
    ) u_rom (
      .clk  (Clk),
      .rst  (Reset),
      .en   (rom_stage),
      .addr (ph[PHASE_W-1 -: LUT_ADDR_W]),
      .q    (rom_q)
    );

    assign Data[k*DATA_W +: DATA_W] = data_q;
  end

endmodule

// File: tb/tb_dds_multich_dac.sv
// Scoreboard bench for dds_multich_dac: expected samples are queued per DAC
// write edge and checked by an independent monitor.
module tb_dds_multich_dac;

  localparam int unsigned DW   = 14;
  localparam longint      BASE = 262144;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic [1:0]    Freq_Step;
  logic [1:0]    Phase_Step;
  logic [3:0]    Mode_Sel;
  logic [1:0]    Sweep_En;
  logic [2*DW-1:0] Data;
  logic [1:0]    Dac_Clk;
  logic [1:0]    Dac_Wrt;

  dds_multich_dac #(.FTW_BASE(32'(BASE))) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Freq_Step  (Freq_Step),
    .Phase_Step (Phase_Step),
    .Mode_Sel   (Mode_Sel),
    .Sweep_En   (Sweep_En),
    .Data       (Data),
    .Dac_Clk    (Dac_Clk),
    .Dac_Wrt    (Dac_Wrt)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    int            cyc;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    bit            c0;
    bit            c1;
  } exp_t;

  exp_t   sb[$];
  int     vectors = 0;
  int     errors  = 0;
  int     cyc     = 0;
  int     hi_len  = 0;
  logic   wrt_d   = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Rise n of Dac_Wrt after release is expected at cycle 2+4n.
  task automatic push(input int n, input longint d0, input longint d1, input bit c0, input bit c1);
    exp_t e;
    e.cyc = 2 + 4 * n;
    e.d0  = DW'(d0);
    e.d1  = DW'(d1);
    e.c0  = c0;
    e.c1  = c1;
    sb.push_back(e);
  endtask

  always @(posedge Clk) begin : monitor
    exp_t e;
    #1;
    if (Reset) begin
      cyc    = 0;
      hi_len = 0;
      wrt_d  = 1'b0;
    end else begin
      cyc++;
      if (Dac_Wrt[0]) hi_len++;
      if (Dac_Wrt[0] && !wrt_d && sb.size() > 0) begin
        e = sb.pop_front();
        check("rise_cycle", longint'(cyc), longint'(e.cyc));
        check("dac_clk_wrt_high", longint'({Dac_Clk, Dac_Wrt}), 64'd15);
        if (e.c0) check("data_ch0", longint'(Data[DW-1:0]), longint'(e.d0));
        if (e.c1) check("data_ch1", longint'(Data[2*DW-1:DW]), longint'(e.d1));
      end
      if (!Dac_Wrt[0] && wrt_d) begin
        check("wrt_high_len", longint'(hi_len), 64'd2);
        hi_len = 0;
      end
      wrt_d = Dac_Wrt[0];
    end
  end

  task automatic start_test(input logic [3:0] modes, input logic [1:0] sweep);
    @(negedge Clk);
    Reset      = 1'b1;
    Freq_Step  = '0;
    Phase_Step = '0;
    Mode_Sel   = modes;
    Sweep_En   = sweep;
    repeat (3) @(negedge Clk);
  endtask

  // Called at a negedge; pulse c is seen by the (c+1)-th edge after release.
  task automatic release_pulses(input int f0, input int f1, input int p0, input int p1);
    Reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      Freq_Step  = {c < f1, c < f0};
      Phase_Step = {c < p1, c < p0};
      @(negedge Clk);
    end
    Freq_Step  = '0;
    Phase_Step = '0;
  endtask

  task automatic drain(input string name, input int budget);
    int i = 0;
    while (sb.size() > 0 && i < budget) begin
      @(negedge Clk);
      i++;
    end
    check(name, longint'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    longint acc;
    longint cur;
    Freq_Step  = '0;
    Phase_Step = '0;
    Sweep_En   = '0;
    Mode_Sel   = 4'b1111;

    // Reset held 200 ns.
    #190;
    check("reset_data", longint'(Data), 64'd0);
    check("reset_dac_wrt", longint'(Dac_Wrt), 64'd0);
    check("reset_dac_clk", longint'(Dac_Clk), 64'd0);
    @(negedge Clk);

    // Sawtooth, 7 phase steps on ch0 bring it near the top so it wraps.
    push(0, 0, 0, 1, 1);
    push(1, 4097, 1, 1, 1);
    push(2, 12290, 2, 1, 1);
    for (int n = 3; n <= 2050; n++) push(n, n + 14336, n, 1, 1);
    release_pulses(0, 0, 7, 0);
    drain("drain_saw_wrap", 2060 * 4);

    // Three freq steps on ch0: first two before the first strobe, third in it.
    start_test(4'b1111, 2'b00);
    push(0, 0, 0, 1, 1);
    for (int n = 1; n <= 12; n++) push(n, 4 + 8 * (n - 1), n, 1, 1);
    release_pulses(3, 0, 0, 0);
    drain("drain_freq3", 100);

    // Eight steps on ch0 wrap the index; three on ch1 in the same cycles.
    start_test(4'b1111, 2'b00);
    push(0, 0, 0, 1, 1);
    push(1, 4, 4, 1, 1);
    push(2, 68, 12, 1, 1);
    for (int n = 3; n <= 12; n++) push(n, n + 66, 4 + 8 * (n - 1), 1, 1);
    release_pulses(8, 3, 0, 0);
    drain("drain_freq8", 100);

    // Two phase steps on ch1: quarter-scale offset against ch0.
    start_test(4'b1111, 2'b00);
    push(0, 0, 0, 1, 1);
    for (int n = 1; n <= 8; n++) push(n, n, n + 4096, 1, 1);
    release_pulses(0, 0, 0, 2);
    drain("drain_phase", 80);

    // ch0 square at top index (128-sample period); ch1 freq+phase step together.
    start_test({2'd3, 2'd1}, 2'b00);
    push(0, 0, 0, 1, 1);
    for (int n = 1; n <= 140; n++)
      push(n, ((n <= 65) || (n >= 130)) ? 16383 : 0, 2 * n + 2048, 1, 1);
    release_pulses(7, 1, 0, 1);
    drain("drain_square", 150 * 4);

    // ch0 sine from reset starts at midscale; ch1 triangle rising.
    start_test({2'd2, 2'd0}, 2'b00);
    push(0, 0, 0, 1, 1);
    for (int n = 1; n <= 6; n++) push(n, 8192, 2 * n, 1, 1);
    release_pulses(0, 0, 0, 0);
    drain("drain_sine", 60);

    // Reset mid-sample while the write strobe is high.
    for (int i = 0; i < 20 && Dac_Wrt[0] !== 1'b1; i++) @(posedge Clk);
    check("wait_wrt_high", longint'(Dac_Wrt[0]), 64'd1);
    #5;
    check("pre_reset_sine", longint'(Data[DW-1:0]), 64'd8192);
    Reset = 1'b1;
    #1;
    check("mid_reset_data", longint'(Data), 64'd0);
    check("mid_reset_dac_wrt", longint'(Dac_Wrt), 64'd0);
    check("mid_reset_dac_clk", longint'(Dac_Clk), 64'd0);

    // Sweep on ch0 with idx 1; without the sweep build the FTW stays 2*base.
    start_test(4'b1111, 2'b01);
`ifdef DDS_SWEEP_EN
    cur = BASE;
`else
    cur = 2 * BASE;
`endif
    acc = 0;
    push(0, 0, 0, 1, 1);
    for (int n = 1; n <= 300; n++) begin
      acc = (acc + cur) & 64'hFFFF_FFFF;
      push(n, acc >> 18, n, 1, 1);
`ifdef DDS_SWEEP_EN
      cur = (cur >= 2 * BASE) ? BASE : cur + 1000;
`endif
    end
    release_pulses(1, 0, 0, 0);
    drain("drain_sweep", 310 * 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
